ahblite_busmatrix_decoder: RTL and testbench

Per-master decode stage sitting directly downstream of the bus-matrix input stage. Decodes the held or live address-phase signals into one of four slave-port requests, or a built-in default slave on a miss. Tracks which target owns the current data phase and returns ACTIVE_Decoder, HREADYOUT_Decoder and HRESP_Decoder to the input stage. The default slave produces the AHB-Lite two-cycle ERROR response for unmapped addresses.

---
 rtl/ahblite_busmatrix_pkg.sv | 24 ++
 rtl/ahblite_busmatrix_default_slave.sv | 59 +++++
 rtl/ahblite_busmatrix_decoder.sv | 109 ++++++++++
 tb/tb_ahblite_busmatrix_decoder.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/ahblite_busmatrix_pkg.sv
// Shared types and constants for the AHB-Lite bus-matrix decode path.
// Ports: none (package only).
// Holds HTRANS/HRESP codes, the default-slave state type and the slave-port count.
package ahblite_busmatrix_pkg;

  localparam int NUM_SLV = 4;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [1:0] {
    DS_IDLE = 2'b00,
    DS_ERR1 = 2'b01,
    DS_ERR2 = 2'b10
  } dflt_state_t;

endpackage

// File: rtl/ahblite_busmatrix_default_slave.sv
// Default slave answering unmapped addresses with the two-cycle AHB-Lite ERROR response.
// Ports: clk, rst_n (sync, active-low), acc_miss strobe in; ready, resp, busy (ERR1) out;
// err_count out only when DECODER_ERRCNT_EN is defined (saturating count of accepted misses).
module ahblite_busmatrix_default_slave
  import ahblite_busmatrix_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        acc_miss,
  output logic        ready,
  output logic [1:0]  resp,
  output logic        busy
`ifdef DECODER_ERRCNT_EN
  ,
  output logic [15:0] err_count
`endif
);

  dflt_state_t state, state_d;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= DS_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    ready   = 1'b1;
    resp    = HRESP_OKAY;
    busy    = 1'b0;
    unique case (state)
      DS_IDLE: begin
        if (acc_miss) state_d = DS_ERR1;
      end
      DS_ERR1: begin
        ready   = 1'b0;
        resp    = HRESP_ERROR;
        busy    = 1'b1;
        state_d = DS_ERR2;
      end
      DS_ERR2: begin
        resp    = HRESP_ERROR;
        // Second ERROR cycle is a ready cycle, so a pended miss can be taken here.
        state_d = acc_miss ? DS_ERR1 : DS_IDLE;
      end
      default: state_d = DS_IDLE;
    endcase
  end

`ifdef DECODER_ERRCNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      err_count <= 16'h0000;
    else if (acc_miss && (err_count != 16'hFFFF))
      err_count <= err_count + 16'h0001;
  end
`endif

endmodule

// File: rtl/ahblite_busmatrix_decoder.sv
// Per-master address decoder: maps the input-stage address onto four slave ports or the default slave.
// Ports: HCLK, HRESETn (sync, active-low); address/transfer from input stage; grant/ready/resp per
// output stage; SEL/ACTIVE/HREADYOUT/HRESP back. ERR_COUNT exists only with DECODER_ERRCNT_EN defined.
module ahblite_busmatrix_decoder
  import ahblite_busmatrix_pkg::*;
#(
  parameter logic [31:0] S0_BASE = 32'h0000_0000,
  parameter logic [31:0] S0_MASK = 32'hE000_0000,
  parameter logic [31:0] S1_BASE = 32'h2000_0000,
  parameter logic [31:0] S1_MASK = 32'hE000_0000,
  parameter logic [31:0] S2_BASE = 32'h4000_0000,
  parameter logic [31:0] S2_MASK = 32'hF000_0000,
  parameter logic [31:0] S3_BASE = 32'h6000_0000,
  parameter logic [31:0] S3_MASK = 32'hE000_0000
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic [31:0]          HADDR_Inputstage,
  input  logic [1:0]           HTRANS_Inputstage,
  input  logic                 TRANS_HOLD,
  input  logic [NUM_SLV-1:0]   ACTIVE_Outputstage,
  input  logic [NUM_SLV-1:0]   HREADYOUT_Outputstage,
  input  logic [2*NUM_SLV-1:0] HRESP_Outputstage,
  output logic [NUM_SLV-1:0]   SEL_Outputstage,
  output logic                 ACTIVE_Decoder,
  output logic                 HREADYOUT_Decoder,
  output logic [1:0]           HRESP_Decoder
`ifdef DECODER_ERRCNT_EN
  ,
  output logic [15:0]          ERR_COUNT
`endif
);

  localparam logic [31:0] SLV_BASE [NUM_SLV] = '{S0_BASE, S1_BASE, S2_BASE, S3_BASE};
  localparam logic [31:0] SLV_MASK [NUM_SLV] = '{S0_MASK, S1_MASK, S2_MASK, S3_MASK};

  logic [NUM_SLV-1:0] hit;
  logic [NUM_SLV-1:0] hit_pri;
  logic               miss;
  logic               dflt_req;
  logic               accept;
  logic               acc_miss;
  logic [NUM_SLV:0]   dp_sel;     // bit NUM_SLV = default slave
  logic               dflt_ready;
  logic [1:0]         dflt_resp;
  logic               dflt_busy;

  // The input stage already qualifies HTRANS into TRANS_HOLD; the raw code is not needed here.
  logic unused_htrans;
  assign unused_htrans = ^HTRANS_Inputstage;

  // Region match, then keep only the lowest matching index so overlaps resolve deterministically.
  always_comb begin
    hit     = '0;
    hit_pri = '0;
    for (int i = 0; i < NUM_SLV; i++)
      hit[i] = ((HADDR_Inputstage & SLV_MASK[i]) == SLV_BASE[i]);
    for (int i = NUM_SLV - 1; i >= 0; i--)
      if (hit[i]) hit_pri = NUM_SLV'(1) << i;
  end

  assign miss            = ~|hit;
  assign SEL_Outputstage = (TRANS_HOLD && !miss) ? hit_pri : '0;
  assign dflt_req        = TRANS_HOLD & miss;

  // Default slave cannot take a new address while in its first (not-ready) ERROR cycle.
  assign ACTIVE_Decoder  = (|(SEL_Outputstage & ACTIVE_Outputstage)) | (dflt_req & ~dflt_busy);
  assign accept          = ACTIVE_Decoder & HREADYOUT_Decoder;
  assign acc_miss        = accept & dflt_req;

  always_ff @(posedge HCLK) begin
    if (!HRESETn)
      dp_sel <= '0;
    else if (accept)
      dp_sel <= {dflt_req, SEL_Outputstage};
    else if (HREADYOUT_Decoder)
      dp_sel <= '0;
  end

  // Data-phase response comes from whichever target owns the data phase; idle reads as OKAY/ready.
  always_comb begin
    HREADYOUT_Decoder = 1'b1;
    HRESP_Decoder     = HRESP_OKAY;
    if (dp_sel[NUM_SLV]) begin
      HREADYOUT_Decoder = dflt_ready;
      HRESP_Decoder     = dflt_resp;
    end
    for (int i = 0; i < NUM_SLV; i++) begin
      if (dp_sel[i]) begin
        HREADYOUT_Decoder = HREADYOUT_Outputstage[i];
        HRESP_Decoder     = HRESP_Outputstage[2*i +: 2];
      end
    end
  end

  ahblite_busmatrix_default_slave u_dflt (
    .clk       (HCLK),
    .rst_n     (HRESETn),
    .acc_miss  (acc_miss),
    .ready     (dflt_ready),
    .resp      (dflt_resp),
    .busy      (dflt_busy)
`ifdef DECODER_ERRCNT_EN
    ,
    .err_count (ERR_COUNT)
`endif
  );

endmodule

// File: tb/tb_ahblite_busmatrix_decoder.sv
// Bench for ahblite_busmatrix_decoder: directed per-cycle vectors with hand-computed expectations.
// Stimulus pushes the expected outputs for each cycle; a negedge monitor pops and compares.
// Also checks ERR_COUNT when DECODER_ERRCNT_EN is defined.
module tb_ahblite_busmatrix_decoder;

  logic        HCLK;
  logic        HRESETn;
  logic [31:0] HADDR_Inputstage;
  logic [1:0]  HTRANS_Inputstage;
  logic        TRANS_HOLD;
  logic [3:0]  ACTIVE_Outputstage;
  logic [3:0]  HREADYOUT_Outputstage;
  logic [7:0]  HRESP_Outputstage;
  logic [3:0]  SEL_Outputstage;
  logic        ACTIVE_Decoder;
  logic        HREADYOUT_Decoder;
  logic [1:0]  HRESP_Decoder;
`ifdef DECODER_ERRCNT_EN
  logic [15:0] ERR_COUNT;
`endif

  ahblite_busmatrix_decoder dut (
    .HCLK                  (HCLK),
    .HRESETn               (HRESETn),
    .HADDR_Inputstage      (HADDR_Inputstage),
    .HTRANS_Inputstage     (HTRANS_Inputstage),
    .TRANS_HOLD            (TRANS_HOLD),
    .ACTIVE_Outputstage    (ACTIVE_Outputstage),
    .HREADYOUT_Outputstage (HREADYOUT_Outputstage),
    .HRESP_Outputstage     (HRESP_Outputstage),
    .SEL_Outputstage       (SEL_Outputstage),
    .ACTIVE_Decoder        (ACTIVE_Decoder),
    .HREADYOUT_Decoder     (HREADYOUT_Decoder),
    .HRESP_Decoder         (HRESP_Decoder)
`ifdef DECODER_ERRCNT_EN
    ,
    .ERR_COUNT             (ERR_COUNT)
`endif
  );

  typedef struct {
    logic [7:0]  outs;   // {sel[3:0], active, ready, resp[1:0]}
    logic [15:0] cnt;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  task automatic step(input logic rst, input logic [31:0] addr, input logic hold,
                      input logic [3:0] act, input logic [3:0] rdyo, input logic [7:0] respo,
                      input logic [3:0] e_sel, input logic e_act, input logic e_rdy,
                      input logic [1:0] e_resp, input logic [15:0] e_cnt, input string name);
    exp_t e;
    @(posedge HCLK);
    #1;
    HRESETn               = rst;
    HADDR_Inputstage      = addr;
    HTRANS_Inputstage     = hold ? 2'b10 : 2'b00;
    TRANS_HOLD            = hold;
    ACTIVE_Outputstage    = act;
    HREADYOUT_Outputstage = rdyo;
    HRESP_Outputstage     = respo;
    e.outs = {e_sel, e_act, e_rdy, e_resp};
    e.cnt  = e_cnt;
    e.name = name;
    exp_q.push_back(e);
  endtask

  // Monitor: outputs are settled mid-cycle, so sample on the falling edge.
  always @(negedge HCLK) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [7:0] got;
      e   = exp_q.pop_front();
      got = {SEL_Outputstage, ACTIVE_Decoder, HREADYOUT_Decoder, HRESP_Decoder};
      n_checks++;
      if (got === e.outs) n_pass++;
      else $display("FAIL %s: {sel,act,rdy,resp} got %b_%b_%b_%b want %b_%b_%b_%b", e.name,
                    got[7:4], got[3], got[2], got[1:0], e.outs[7:4], e.outs[3], e.outs[2], e.outs[1:0]);
`ifdef DECODER_ERRCNT_EN
      n_checks++;
      if (ERR_COUNT === e.cnt) n_pass++;
      else $display("FAIL %s_errcnt: got %0d want %0d", e.name, ERR_COUNT, e.cnt);
`endif
    end
  end

  localparam logic [31:0] MISS_A = 32'hA000_0000;

  initial begin
    HRESETn               = 1'b0;
    HADDR_Inputstage      = '0;
    HTRANS_Inputstage     = 2'b00;
    TRANS_HOLD            = 1'b0;
    ACTIVE_Outputstage    = '0;
    HREADYOUT_Outputstage = 4'hF;
    HRESP_Outputstage     = '0;
    repeat (2) @(posedge HCLK);

    //    rst  addr          hold act    rdyo   respo  sel     a  r  resp  cnt name
    step(0, 32'h0,         0, 4'h0, 4'hF, 8'h00, 4'b0000, 0, 1, 2'b00, 0, "reset0");
    step(0, 32'h0,         0, 4'h0, 4'hF, 8'h00, 4'b0000, 0, 1, 2'b00, 0, "reset1");
    // Slave 1 hit, granted, data phase follows slave-1 ready/resp
    step(1, 32'h2000_0010, 1, 4'h2, 4'hF, 8'h00, 4'b0010, 1, 1, 2'b00, 0, "s1_addr");
    step(1, 32'h0,         0, 4'h0, 4'hD, 8'h00, 4'b0000, 0, 0, 2'b00, 0, "s1_wait");
    step(1, 32'h0,         0, 4'h0, 4'hF, 8'h04, 4'b0000, 0, 1, 2'b01, 0, "s1_done");
    step(1, 32'h0,         0, 4'h0, 4'hF, 8'h04, 4'b0000, 0, 1, 2'b00, 0, "s1_idle");
    // Single miss: two-cycle ERROR then idle
    step(1, MISS_A,        1, 4'h0, 4'hF, 8'h00, 4'b0000, 1, 1, 2'b00, 0, "miss_addr");
    step(1, 32'h0,         0, 4'h0, 4'hF, 8'h00, 4'b0000, 0, 0, 2'b01, 1, "miss_err1");
    step(1, 32'h0,         0, 4'h0, 4'hF, 8'h00, 4'b0000, 0, 1, 2'b01, 1, "miss_err2");
    step(1, 32'h0,         0, 4'h0, 4'hF, 8'h00, 4'b0000, 0, 1, 2'b00, 1, "miss_idle");
    // Slave 2 stalls 3 cycles while slave 0 is requested and granted
    step(1, 32'h4000_0000, 1, 4'h4, 4'hF, 8'h00, 4'b0100, 1, 1, 2'b00, 1, "s2_addr");
    step(1, 32'h0000_0100, 1, 4'h1, 4'hB, 8'h00, 4'b0001, 1, 0, 2'b00, 1, "s2_stall1");
    step(1, 32'h0000_0100, 1, 4'h1, 4'hB, 8'h00, 4'b0001, 1, 0, 2'b00, 1, "s2_stall2");
    step(1, 32'h0000_0100, 1, 4'h1, 4'hB, 8'h00, 4'b0001, 1, 0, 2'b00, 1, "s2_stall3");
    step(1, 32'h0000_0100, 1, 4'h1, 4'hF, 8'h00, 4'b0001, 1, 1, 2'b00, 1, "s0_accept");
    step(1, 32'h0,         0, 4'h0, 4'hE, 8'h00, 4'b0000, 0, 0, 2'b00, 1, "s0_dp_wait");
    step(1, 32'h0,         0, 4'h0, 4'hF, 8'h00, 4'b0000, 0, 1, 2'b00, 1, "s0_dp_done");
    // Two back-to-back misses: second pends through ERR1, taken in ERR2
    step(1, MISS_A,        1, 4'h0, 4'hF, 8'h00, 4'b0000, 1, 1, 2'b00, 1, "mm_addr1");
    step(1, MISS_A,        1, 4'h0, 4'hF, 8'h00, 4'b0000, 0, 0, 2'b01, 2, "mm_err1a");
    step(1, MISS_A,        1, 4'h0, 4'hF, 8'h00, 4'b0000, 1, 1, 2'b01, 2, "mm_err2a");
    step(1, 32'h0,         0, 4'h0, 4'hF, 8'h00, 4'b0000, 0, 0, 2'b01, 3, "mm_err1b");
    step(1, 32'h0,         0, 4'h0, 4'hF, 8'h00, 4'b0000, 0, 1, 2'b01, 3, "mm_err2b");
    step(1, 32'h0,         0, 4'h0, 4'hF, 8'h00, 4'b0000, 0, 1, 2'b00, 3, "mm_idle");
    // Slave 3 requested but not granted for two cycles
    step(1, 32'h6000_1000, 1, 4'h0, 4'hF, 8'h00, 4'b1000, 0, 1, 2'b00, 3, "s3_nogrant1");
    step(1, 32'h6000_1000, 1, 4'h0, 4'hF, 8'h00, 4'b1000, 0, 1, 2'b00, 3, "s3_nogrant2");
    step(1, 32'h6000_1000, 1, 4'h8, 4'hF, 8'h00, 4'b1000, 1, 1, 2'b00, 3, "s3_grant");
    step(1, 32'h0,         0, 4'h0, 4'h7, 8'h40, 4'b0000, 0, 0, 2'b01, 3, "s3_dp_wait");
    step(1, 32'h0,         0, 4'h0, 4'hF, 8'h00, 4'b0000, 0, 1, 2'b00, 3, "s3_dp_done");
    // Reset during slave 1 stall
    step(1, 32'h2000_0000, 1, 4'h2, 4'hF, 8'h00, 4'b0010, 1, 1, 2'b00, 3, "rst_s1_addr");
    step(0, 32'h0,         0, 4'h0, 4'hD, 8'h00, 4'b0000, 0, 0, 2'b00, 3, "rst_s1_low");
    step(1, 32'h0,         0, 4'h0, 4'hD, 8'h00, 4'b0000, 0, 1, 2'b00, 0, "rst_s1_after");
    // Reset during default-slave ERR1
    step(1, MISS_A,        1, 4'h0, 4'hF, 8'h00, 4'b0000, 1, 1, 2'b00, 0, "rst_miss_addr");
    step(0, 32'h0,         0, 4'h0, 4'hF, 8'h00, 4'b0000, 0, 0, 2'b01, 1, "rst_miss_low");
    step(1, 32'h0,         0, 4'h0, 4'hF, 8'h00, 4'b0000, 0, 1, 2'b00, 0, "rst_miss_after");
    // Three misses after reset
    step(1, MISS_A,        1, 4'h0, 4'hF, 8'h00, 4'b0000, 1, 1, 2'b00, 0, "m3_addr1");
    step(1, 32'h0,         0, 4'h0, 4'hF, 8'h00, 4'b0000, 0, 0, 2'b01, 1, "m3_err1a");
    step(1, MISS_A,        1, 4'h0, 4'hF, 8'h00, 4'b0000, 1, 1, 2'b01, 1, "m3_addr2");
    step(1, 32'h0,         0, 4'h0, 4'hF, 8'h00, 4'b0000, 0, 0, 2'b01, 2, "m3_err1b");
    step(1, MISS_A,        1, 4'h0, 4'hF, 8'h00, 4'b0000, 1, 1, 2'b01, 2, "m3_addr3");
    step(1, 32'h0,         0, 4'h0, 4'hF, 8'h00, 4'b0000, 0, 0, 2'b01, 3, "m3_err1c");
    step(1, 32'h0,         0, 4'h0, 4'hF, 8'h00, 4'b0000, 0, 1, 2'b01, 3, "m3_err2c");
    step(1, 32'h0,         0, 4'h0, 4'hF, 8'h00, 4'b0000, 0, 1, 2'b00, 3, "m3_idle");

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge HCLK);
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
